event_emitter: RTL

//   Transmit side of the asynchronous event link. Converts one-cycle synchronous spike

---
 rtl/event_link_pkg.sv | 20 ++
 rtl/event_emitter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/event_link_pkg.sv
// Shared definitions for the asynchronous event link (transmit and receive sides).
//   - state_t    : emitter FSM encoding (IDLE=0, PULSE=1, GAP=2)
//   - DROP_CNT_W : width of the optional dropped-request counter
//   - max_u      : helper for sizing counters from two parameters
package event_link_pkg;

   localparam int unsigned DROP_CNT_W = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      GAP   = 2'd2
   } state_t;

   // Larger of two unsigned values, usable in constant expressions.
   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/event_emitter.sv
// Transmit side of the asynchronous event link. Turns one-cycle spike requests into
// clean pulses (PULSE_W high, at least GAP_W low) for a remote edge-capture
// synchronizer. Requests arriving while a pulse is in flight are queued in a
// saturating pending counter; requests beyond its depth are dropped.
//
// Ports:
//   i_clk       in   1       system clock, rising edge
//   i_rst       in   1       asynchronous reset, active-high
//   i_spike     in   1       spike request, one request per high cycle
//   o_event     out  1       registered event pulse to the link
//   o_busy      out  1       registered, high when FSM not idle or requests queued
//   o_drop      out  1       one-cycle pulse, a request was dropped (queue full)
//   o_pending   out  PEND_W  current pending count
//   o_drop_cnt  out  16      saturating dropped-request count (only with
//                            EVENT_EMITTER_DROP_CNT_EN defined)
//
// Configuration macro: EVENT_EMITTER_DROP_CNT_EN adds o_drop_cnt.
module event_emitter
   import event_link_pkg::*;
#(
   parameter int unsigned PULSE_W = 2,
   parameter int unsigned GAP_W   = 2,
   parameter int unsigned PEND_W  = 4
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_spike,
   output logic              o_event,
   output logic              o_busy,
   output logic              o_drop,
`ifdef EVENT_EMITTER_DROP_CNT_EN
   output logic [DROP_CNT_W-1:0] o_drop_cnt,
`endif
   output logic [PEND_W-1:0] o_pending
);

   // Timer only ever holds PULSE_W-1 or GAP_W-1, so clog2 of the larger suffices.
   localparam int unsigned TMR_MAX = max_u(PULSE_W, GAP_W);
   localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

   state_t              r_state;
   logic [TMR_W-1:0]    r_timer;
   logic [PEND_W-1:0]   r_pending;
   logic                r_event;
   logic                r_busy;
   logic                r_drop;

   state_t              w_state_nxt;
   logic [TMR_W-1:0]    w_timer_nxt;
   logic [PEND_W-1:0]   w_pending_nxt;
   logic                w_event_nxt;
   logic                w_busy_nxt;
   logic                w_drop_nxt;

   logic                w_timer_zero;
   logic                w_pend_nz;
   logic                w_pend_full;
   logic                w_launch_pt;
   logic                w_launch;

   assign w_timer_zero = (r_timer == TMR_W'(0));
   assign w_pend_nz    = |r_pending;
   assign w_pend_full  = &r_pending;

   // A new pulse may start from IDLE or from the final GAP cycle (no idle bubble).
   assign w_launch_pt  = (r_state == IDLE) || ((r_state == GAP) && w_timer_zero);
   assign w_launch     = w_launch_pt && (i_spike || w_pend_nz);

   // Next-state, timer, pending counter and output decode.
   always_comb begin
      w_state_nxt   = r_state;
      w_timer_nxt   = r_timer;
      w_pending_nxt = r_pending;
      w_event_nxt   = r_event;
      w_drop_nxt    = 1'b0;

      case (r_state)
         IDLE: begin
            w_event_nxt = 1'b0;
         end
         PULSE: begin
            if (w_timer_zero) begin
               w_state_nxt = GAP;
               w_timer_nxt = TMR_W'(GAP_W - 1);
               w_event_nxt = 1'b0;
            end else begin
               w_timer_nxt = r_timer - TMR_W'(1);
               w_event_nxt = 1'b1;
            end
         end
         GAP: begin
            w_event_nxt = 1'b0;
            if (w_timer_zero) begin
               w_state_nxt = IDLE;
            end else begin
               w_timer_nxt = r_timer - TMR_W'(1);
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_timer_nxt = TMR_W'(0);
            w_event_nxt = 1'b0;
         end
      endcase

      if (w_launch) begin
         w_state_nxt = PULSE;
         w_timer_nxt = TMR_W'(PULSE_W - 1);
         w_event_nxt = 1'b1;
      end

      // Launch from the queue consumes one entry; a same-cycle spike refills it.
      if (w_launch) begin
         if (w_pend_nz && !i_spike) begin
            w_pending_nxt = r_pending - PEND_W'(1);
         end
      end else if (i_spike) begin
         if (w_pend_full) begin
            w_drop_nxt = 1'b1;
         end else begin
            w_pending_nxt = r_pending + PEND_W'(1);
         end
      end

      w_busy_nxt = (w_state_nxt != IDLE) || (w_pending_nxt != PEND_W'(0));
   end

   // State and output registers.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state   <= IDLE;
         r_timer   <= TMR_W'(0);
         r_pending <= PEND_W'(0);
         r_event   <= 1'b0;
         r_busy    <= 1'b0;
         r_drop    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_timer   <= w_timer_nxt;
         r_pending <= w_pending_nxt;
         r_event   <= w_event_nxt;
         r_busy    <= w_busy_nxt;
         r_drop    <= w_drop_nxt;
      end
   end

`ifdef EVENT_EMITTER_DROP_CNT_EN
   logic [DROP_CNT_W-1:0] r_drop_cnt;

   // Saturating count of dropped requests, aligned with o_drop.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_drop_cnt <= DROP_CNT_W'(0);
      end else if (w_drop_nxt && (r_drop_cnt != {DROP_CNT_W{1'b1}})) begin
         r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
      end
   end

   assign o_drop_cnt = r_drop_cnt;
`endif

   assign o_event   = r_event;
   assign o_busy    = r_busy;
   assign o_drop    = r_drop;
   assign o_pending = r_pending;

endmodule
